// File: rtl/sm83_dbg_uart_pkg.sv
// Shared types and constants for the SM83 debug UART bridge.
// SM83_DBG_UART_PARITY_EN selects 8E1 framing; undefined gives 8N1.
package sm83_dbg_uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

`ifdef SM83_DBG_UART_PARITY_EN
  localparam bit PARITY_EN = 1'b1;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;
`else
  localparam bit PARITY_EN = 1'b0;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;
`endif

endpackage

// File: rtl/sm83_dbg_uart_fifo.sv
// Synchronous FIFO for received bytes; extra pointer bit separates full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sm83_dbg_uart_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-2:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-2:0]] <= wdata_i;
  end

endmodule

// File: rtl/sm83_dbg_uart.sv
// UART RX/TX bridge for the SM83 debug interface using toggle-seq handshakes.
// Define SM83_DBG_UART_PARITY_EN for 8E1 framing; the default build is 8N1.
module sm83_dbg_uart
  import sm83_dbg_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      rx_i,
  output logic                      tx_o,
  output logic [UART_DATA_BITS-1:0] data_rx_o,
  output logic                      data_rx_valid_o,
  output logic                      data_rx_seq_o,
  input  logic                      data_rx_ack_i,
  input  logic [UART_DATA_BITS-1:0] data_tx_i,
  input  logic                      data_tx_seq_i,
  output logic                      data_tx_ack_o,
  output logic                      rx_frame_err_o,
  output logic                      rx_overrun_o
);

  localparam int unsigned CntW    = $clog2(BAUD_DIV + 1);
  localparam int unsigned BitW    = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] FullBit = CntW'(BAUD_DIV);
  localparam logic [CntW-1:0] HalfBit = CntW'(BAUD_DIV / 2);
  localparam logic [BitW-1:0] LastBit = BitW'(UART_DATA_BITS - 1);

  // ---------------------------------------------------------------- RX
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q && !rx_sync_q;

  rx_state_e                 rx_state_q, rx_state_d;
  logic [CntW-1:0]           rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]           rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rx_par_err_q, rx_par_err_d;
  logic                      rx_tick, rx_push, rx_bad;

  assign rx_tick = (rx_cnt_q == CntW'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_err_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_err_q <= rx_par_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_err_d = rx_par_err_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = HalfBit;
        end
      end
      RxStart: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else if (!rx_sync_q) begin
          rx_state_d   = RxData;
          rx_cnt_d     = FullBit;
          rx_bit_d     = '0;
          rx_par_err_d = 1'b0;
        end else begin
          rx_state_d = RxIdle;  // start glitch shorter than half a bit
        end
      end
      RxData: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          rx_cnt_d   = FullBit;
          if (rx_bit_q == LastBit) begin
`ifdef SM83_DBG_UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end
        end
      end
`ifdef SM83_DBG_UART_PARITY_EN
      RxParity: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
          rx_cnt_d     = FullBit;
          rx_state_d   = RxStop;
        end
      end
`endif
      RxStop: begin
        // Leave at the stop-bit centre so the next start edge is never missed.
        if (!rx_tick) rx_cnt_d = rx_cnt_q - 1'b1;
        else          rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    rx_bad  = 1'b0;
    if ((rx_state_q == RxStop) && rx_tick) begin
      if (rx_sync_q && !(PARITY_EN && rx_par_err_q)) rx_push = 1'b1;
      else                                          rx_bad  = 1'b1;
    end
  end

  // ------------------------------------------------ RX FIFO and output stage
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [UART_DATA_BITS-1:0] data_rx_q;
  logic                      data_rx_seq_q, frame_err_q, overrun_q;

  sm83_dbg_uart_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_pop = (data_rx_seq_q == data_rx_ack_i) && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_rx_q     <= '0;
      data_rx_seq_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        data_rx_q     <= fifo_rdata;
        data_rx_seq_q <= !data_rx_seq_q;
      end
      frame_err_q <= rx_bad;
      overrun_q   <= rx_push && fifo_full && !fifo_pop;
    end
  end

  assign data_rx_o       = data_rx_q;
  assign data_rx_seq_o   = data_rx_seq_q;
  assign data_rx_valid_o = (data_rx_seq_q != data_rx_ack_i);
  assign rx_frame_err_o  = frame_err_q;
  assign rx_overrun_o    = overrun_q;

  // ---------------------------------------------------------------- TX
  tx_state_e                 tx_state_q, tx_state_d;
  logic [CntW-1:0]           tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]           tx_bit_q, tx_bit_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      tx_ack_q, tx_ack_d;
  logic                      tx_tick, tx_pending;
`ifdef SM83_DBG_UART_PARITY_EN
  logic                      tx_par_q, tx_par_d;
`endif

  assign tx_tick    = (tx_cnt_q == CntW'(1));
  assign tx_pending = (data_tx_seq_i != tx_ack_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_ack_q   <= 1'b0;
`ifdef SM83_DBG_UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_ack_q   <= tx_ack_d;
`ifdef SM83_DBG_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_ack_d   = tx_ack_q;
`ifdef SM83_DBG_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TxStart: begin
        if (!tx_tick) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = TxData;
          tx_cnt_d   = FullBit;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        if (!tx_tick) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_cnt_d   = FullBit;
          if (tx_bit_q == LastBit) begin
`ifdef SM83_DBG_UART_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
          end
        end
      end
`ifdef SM83_DBG_UART_PARITY_EN
      TxParity: begin
        if (!tx_tick) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = TxStop;
          tx_cnt_d   = FullBit;
        end
      end
`endif
      TxStop: begin
        if (!tx_tick) tx_cnt_d = tx_cnt_q - 1'b1;
        else          tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
    // A pending byte is taken in IDLE or on the last stop cycle: no idle gap.
    if ((tx_state_q == TxIdle || (tx_state_q == TxStop && tx_tick)) && tx_pending) begin
      tx_state_d = TxStart;
      tx_cnt_d   = FullBit;
      tx_shift_d = data_tx_i;
      tx_ack_d   = data_tx_seq_i;
`ifdef SM83_DBG_UART_PARITY_EN
      tx_par_d   = ^data_tx_i;
`endif
    end
  end

  always_comb begin
    tx_o = 1'b1;
    unique case (tx_state_q)
      TxStart:  tx_o = 1'b0;
      TxData:   tx_o = tx_shift_q[0];
`ifdef SM83_DBG_UART_PARITY_EN
      TxParity: tx_o = tx_par_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  assign data_tx_ack_o = tx_ack_q;

endmodule

// File: tb/tb_sm83_dbg_uart.sv
// Self-checking bench for sm83_dbg_uart: directed corner cases plus random RX/TX traffic
// compared against a frame-level model. Honours SM83_DBG_UART_PARITY_EN.
module tb_sm83_dbg_uart;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
`ifdef SM83_DBG_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset, rx, tx;
  logic [7:0] data_rx, data_tx;
  logic       data_rx_valid, data_rx_seq, data_rx_ack;
  logic       data_tx_seq, data_tx_ack, rx_frame_err, rx_overrun;

  always #5 clk = ~clk;

  sm83_dbg_uart #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .rx_i            (rx),
    .tx_o            (tx),
    .data_rx_o       (data_rx),
    .data_rx_valid_o (data_rx_valid),
    .data_rx_seq_o   (data_rx_seq),
    .data_rx_ack_i   (data_rx_ack),
    .data_tx_i       (data_tx),
    .data_tx_seq_i   (data_tx_seq),
    .data_tx_ack_o   (data_tx_ack),
    .rx_frame_err_o  (rx_frame_err),
    .rx_overrun_o    (rx_overrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit i of a frame carrying byte b (start, data LSB first, parity, stop).
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef SM83_DBG_UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Consumer/monitor state: the monitor is the only driver of data_rx_ack.
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0;
  int         ack_req = 0, ack_done = 0, ack_wait = 0;
  bit         auto_ack = 1'b0;
  logic       seen_seq = 1'b0;

  initial begin : monitor
    data_rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_seq    = 1'b0;
        data_rx_ack = 1'b0;
        ack_wait    = 0;
      end else begin
        if (rx_frame_err) fe_cnt++;
        if (rx_overrun) ov_cnt++;
        if (data_rx_seq !== seen_seq) begin
          got_q.push_back(data_rx);
          seen_seq = data_rx_seq;
          ack_wait = $urandom_range(0, 3);
        end
        if (data_rx_valid && (auto_ack || ack_done < ack_req)) begin
          if (ack_wait == 0) begin
            data_rx_ack = data_rx_seq;
            if (!auto_ack) ack_done++;
          end else begin
            ack_wait--;
          end
        end
      end
    end
  end

  // bad: 0 good frame, 1 stop bit low, 2 wrong parity (stop low in 8N1).
  task automatic uart_send(input logic [7:0] b, input int bad);
    for (int i = 0; i < NBITS; i++) begin
      rx = frame_bit(b, i);
`ifdef SM83_DBG_UART_PARITY_EN
      if (i == 9 && bad == 2) rx = !rx;
      if (i == NBITS - 1 && bad == 1) rx = 1'b0;
`else
      if (i == NBITS - 1 && bad != 0) rx = 1'b0;
`endif
      repeat (BAUD) @(negedge clk);
    end
    rx = 1'b1;
    if (bad != 0) repeat (BAUD) @(negedge clk);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
    check("rx_byte_count", got_q.size(), n);
  endtask

  task automatic ack_one();
    ack_req++;
    for (int i = 0; i < 20 && ack_done < ack_req; i++) @(negedge clk);
    check("rx_ack_taken", ack_done, ack_req);
  endtask

  task automatic tx_watch(input logic [7:0] b, input bit chain, input logic [7:0] nb);
    for (int k = 1; k <= NBITS * BAUD; k++) begin
      @(negedge clk);
      if (k == 1) check("tx_ack", data_tx_ack, data_tx_seq);
      if ((k - 1) % BAUD == 0 || k % BAUD == 0)
        check($sformatf("tx_bit%0d_k%0d", (k - 1) / BAUD, k), tx, frame_bit(b, (k - 1) / BAUD));
      if (chain && k == 4 * BAUD) begin
        data_tx     = nb;
        data_tx_seq = !data_tx_seq;
      end
      if (chain && k == 4 * BAUD + 1) check("tx_ack_busy", data_tx_ack, !data_tx_seq);
    end
  endtask

  task automatic tx_send(input logic [7:0] b, input bit chain, input logic [7:0] nb);
    @(negedge clk);
    data_tx     = b;
    data_tx_seq = !data_tx_seq;
    tx_watch(b, chain, nb);
    if (chain) tx_watch(nb, 1'b0, 8'h00);
    @(negedge clk);
    check("tx_idle", tx, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b, nb;
    logic [7:0] exp_q[$];
    int         bad, fe0, ov0;
    logic       seq0;

    rx = 1'b1; data_tx = 8'h00; data_tx_seq = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_data_rx", data_rx, 8'h00);
    check("rst_valid", data_rx_valid, 1'b0);
    check("rst_rx_seq", data_rx_seq, 1'b0);
    check("rst_tx_ack", data_tx_ack, 1'b0);
    check("rst_pulses", {rx_frame_err, rx_overrun}, 2'b00);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte and handshake.
    got_q.delete();
    uart_send(8'hA5, 0);
    wait_got(1, 40);
    check("a5_data", data_rx, 8'hA5);
    check("a5_seq", data_rx_seq, 1'b1);
    check("a5_valid", data_rx_valid, 1'b1);
    ack_one();
    @(negedge clk);
    check("a5_valid_after_ack", data_rx_valid, 1'b0);

    // Burst of six with no consumer: holding register + 4 FIFO entries, sixth overruns.
    got_q.delete();
    ov0 = ov_cnt;
    for (int i = 1; i <= 6; i++) uart_send(8'(i), 0);
    repeat (20) @(negedge clk);
    check("burst_overrun", ov_cnt - ov0, 1);
    check("burst_held", data_rx, 8'h01);
    check("burst_valid", data_rx_valid, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      ack_one();
      if (i < 5) begin
        wait_got(i + 1, 40);
        check($sformatf("burst_byte%0d", i + 1), data_rx, 8'(i + 1));
      end
    end
    repeat (40) @(negedge clk);
    check("burst_drained_valid", data_rx_valid, 1'b0);
    check("burst_total", got_q.size(), 5);

    // Short low glitch must not produce a byte or an error.
    got_q.delete();
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_byte", got_q.size(), 0);
    check("glitch_no_err", fe_cnt - fe0, 0);
    b = 8'($urandom);
    uart_send(b, 0);
    wait_got(1, 40);
    check("after_glitch_data", data_rx, b);
    ack_one();

    // Bad stop bit: error pulse, byte dropped.
    got_q.delete();
    fe0  = fe_cnt;
    seq0 = data_rx_seq;
    uart_send(8'h3C, 1);
    check("stop_err_pulse", fe_cnt - fe0, 1);
    check("stop_err_seq", data_rx_seq, seq0);
    check("stop_err_no_byte", got_q.size(), 0);
`ifdef SM83_DBG_UART_PARITY_EN
    uart_send(8'h07, 2);
    check("parity_err_pulse", fe_cnt - fe0, 2);
    check("parity_err_no_byte", got_q.size(), 0);
`endif

    // Random RX traffic against a queue model, with a prompt consumer.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    auto_ack = 1'b1;
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      uart_send(b, bad);
      if (bad == 0) exp_q.push_back(b);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_got(exp_q.size(), 400);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_rx%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    check("rand_rx_frame_errs", fe_cnt - fe0, 16 - exp_q.size());
    check("rand_rx_overruns", ov_cnt - ov0, 0);
    repeat (10) @(negedge clk);
    auto_ack = 1'b0;

    // TX: known pattern chained with a second byte toggled mid-frame, then random frames.
    nb = 8'($urandom);
    tx_send(8'h3C, 1'b1, nb);
    tx_send(8'h07, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) begin
      b  = 8'($urandom);
      nb = 8'($urandom);
      tx_send(b, 1'($urandom_range(0, 1)), nb);
    end

    // Reset in the middle of a TX frame.
    @(negedge clk);
    data_tx     = 8'h00;
    data_tx_seq = !data_tx_seq;
    repeat (50) @(negedge clk);
    check("midtx_line_low", tx, 1'b0);
    reset       = 1'b1;
    data_tx_seq = 1'b0;
    @(negedge clk);
    check("midtx_reset_tx", tx, 1'b1);
    check("midtx_reset_ack", data_tx_ack, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 2 * BAUD; k++) begin
      @(negedge clk);
      if (k == 2 * BAUD - 1) check("midtx_stays_idle", tx, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
